cmp_iter: RTL

Multi-cycle, slice-serial branch comparator for the RISC-V branch path. It is the parametrised successor to the combinational `cmp` unit and uses the same `CMP_OP_*` encoding from cmp.vh (BEQ, BNE, BLT, BGE, BLTU, BGEU). Operands are compared SLICE bits per cycle, MSB slice first, with optional early exit on the first differing slice. A valid/ready handshake sits on both input and output, so the block can live in an area-constrained or multi-cycle execute stage.

---
 rtl/cmp_iter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cmp_iter.sv
// Slice-serial branch comparator: compares SLICE bits per cycle, MSB slice first,
// with valid/ready handshakes on request and result.
`ifndef CMP_OP_WIDTH
`define CMP_OP_WIDTH 3
`define CMP_OP_BEQ   3'd0
`define CMP_OP_BNE   3'd1
`define CMP_OP_BLT   3'd2
`define CMP_OP_BGE   3'd3
`define CMP_OP_BLTU  3'd4
`define CMP_OP_BGEU  3'd5
`endif

// state | meaning
// IDLE  | o_ready=1, waiting for a request
// RUN   | stepping through slices from MSB to LSB
// DONE  | o_valid=1, o_taken held until i_ready
module cmp_iter #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [`CMP_OP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]         i_src1,
  input  logic [WIDTH-1:0]         i_src2,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_taken
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [`CMP_OP_WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]         a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic                     diff_q, diff_d;
  logic                     lt_q, lt_d;
  logic                     taken_q, taken_d;

  logic [WIDTH-1:0]         a_sh, b_sh;
  logic [SLICE-1:0]         a_sl, b_sl;

  function automatic logic resolve(input logic [`CMP_OP_WIDTH-1:0] op,
                                   input logic lt, input logic eq);
    case (op)
      `CMP_OP_BEQ:  resolve = eq;
      `CMP_OP_BNE:  resolve = !eq;
      `CMP_OP_BLT,
      `CMP_OP_BLTU: resolve = lt;
      `CMP_OP_BGE,
      `CMP_OP_BGEU: resolve = !lt;
      default:      resolve = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    lt_d    = lt_q;
    taken_d = taken_q;
    a_sh    = a_q >> (int'(idx_q) * SLICE);
    b_sh    = b_q >> (int'(idx_q) * SLICE);
    a_sl    = a_sh[SLICE-1:0];
    b_sl    = b_sh[SLICE-1:0];

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_d = i_op;
          a_d  = i_src1;
          b_d  = i_src2;
          // Flipping the sign bit of both operands maps signed order onto unsigned order.
          if (i_op == `CMP_OP_BLT || i_op == `CMP_OP_BGE) begin
            a_d[WIDTH-1] = ~i_src1[WIDTH-1];
            b_d[WIDTH-1] = ~i_src2[WIDTH-1];
          end
          idx_d   = IDX_TOP;
          diff_d  = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Only the first (most significant) differing slice decides the order.
        if (!diff_q && (a_sl != b_sl)) begin
          diff_d = 1'b1;
          lt_d   = (a_sl < b_sl);
        end
        if ((diff_d && (EARLY_EXIT != 0)) || (idx_q == '0)) begin
          taken_d = resolve(op_q, lt_d, !diff_d);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      diff_q  <= 1'b0;
      lt_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      lt_q    <= lt_d;
      taken_q <= taken_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_taken = taken_q;

endmodule
